down_timer: RTL

- Loadable down-counter/timer: the count-down counterpart of the team's free-running up-counter.
- Software or a controller FSM loads a terminal count, starts it, and receives a one-cycle `done` pulse when the count reaches zero.
- Modes: one-shot (stops at zero) or periodic (auto-reloads).
- Used for timeouts, baud/tick generation and delay sequencing inside the same subsystem as the up-counter.

---
 rtl/down_timer_pkg.sv | 12 +
 rtl/down_timer_if.sv | 32 +++
 rtl/down_timer_tick_prescaler.sv | 28 ++
 rtl/down_timer.sv | 93 +++++++++
 4 files changed

// File: rtl/down_timer_pkg.sv
// Shared types and defaults for the loadable down-counter timer.
// Optional prescaler is enabled with DOWN_TIMER_PRESCALE_EN.
package down_timer_pkg;

   localparam int DT_WIDTH = 4;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/down_timer_if.sv
// Command/status bundle between a controller and down_timer.
// Optional prescaler (DOWN_TIMER_PRESCALE_EN) does not change this bundle.
interface down_timer_if
   import down_timer_pkg::*;
#(
   parameter int WIDTH = DT_WIDTH
);

   // Commands are level strobes sampled on every rising edge with no backpressure;
   // done is a registered one-cycle pulse and the outputs are always valid.
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             start;
   logic             stop;
   logic             en;
   logic             periodic;
   logic [WIDTH-1:0] count_out;
   logic             busy;
   logic             done;
   state_e           state_dbg;

   modport master (
      output load, load_val, start, stop, en, periodic,
      input  count_out, busy, done, state_dbg
   );

   modport slave (
      input  load, load_val, start, stop, en, periodic,
      output count_out, busy, done, state_dbg
   );

endinterface

// File: rtl/down_timer_tick_prescaler.sv
// Divides enable cycles by PRESCALE into single-cycle decrement ticks.
// Only instantiated when DOWN_TIMER_PRESCALE_EN is defined.
module tick_prescaler #(
   parameter int PRESCALE = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      end
   end

   assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/down_timer.sv
// Loadable down-counter with one-shot / periodic modes and a one-cycle done pulse.
// Define DOWN_TIMER_PRESCALE_EN to decrement only every PRESCALE enabled cycles.
module down_timer
   import down_timer_pkg::*;
#(
   parameter int WIDTH    = DT_WIDTH,
   parameter int PRESCALE = 4
) (
   input  logic        clk,
   input  logic        rst,
   down_timer_if.slave bus
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             done_q, done_d;
   logic             tick;

`ifdef DOWN_TIMER_PRESCALE_EN
   logic presc_clr;

   // Restart the divider whenever the count is re-armed so the first period is full length.
   assign presc_clr = bus.load | bus.stop | ((state_q == S_IDLE) && (state_d == S_RUN));

   tick_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .clr  (presc_clr),
      .en   (bus.en && (state_q == S_RUN)),
      .tick (tick)
   );
`else
   localparam int unused_prescale = PRESCALE;

   assign tick = bus.en;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         count_q  <= '0;
         reload_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      done_d   = 1'b0;

      if (bus.load) begin
         count_d  = bus.load_val;
         reload_d = bus.load_val;
         state_d  = (bus.start && (bus.load_val != '0)) ? S_RUN : S_IDLE;
      end else if (bus.stop) begin
         state_d = S_IDLE;
      end else if (bus.start && (state_q == S_IDLE)) begin
         // A zero count is a zero-length timer: report completion without running.
         if (count_q != '0) begin
            state_d = S_RUN;
         end else begin
            done_d = 1'b1;
         end
      end else if ((state_q == S_RUN) && tick) begin
         if (count_q > WIDTH'(1)) begin
            count_d = count_q - WIDTH'(1);
         end else if (bus.periodic) begin
            count_d = reload_q;
            done_d  = 1'b1;
         end else begin
            count_d = '0;
            state_d = S_IDLE;
            done_d  = 1'b1;
         end
      end
   end

   assign bus.count_out = count_q;
   assign bus.busy      = (state_q == S_RUN);
   assign bus.done      = done_q;
   assign bus.state_dbg = state_q;

endmodule
